// File: rtl/xs3_bcd_seq_conv.sv
// Sequential excess-3 to BCD converter: one nibble per clock, LSD first, valid/ready on both sides.
// Optional XS3_BIDIR_EN adds a dir port selecting the BCD->XS3 encode direction.
module xs3_bcd_seq_conv #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   din,
`ifdef XS3_BIDIR_EN
  input  logic                  dir,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  err,
  output logic [DIGITS-1:0]     err_mask
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      sh_q, sh_d;
  logic [W-1:0]      dout_q, dout_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic              err_q, err_d;

  logic [3:0]        nib;
  logic [3:0]        dig_res;
  logic              dig_bad;

`ifdef XS3_BIDIR_EN
  logic              dir_q, dir_d;
`endif

  // The digit under conversion always sits in the low nibble of the shift register.
  assign nib = sh_q[3:0];

  always_comb begin
    dig_res = 4'hF;
    dig_bad = 1'b1;
`ifdef XS3_BIDIR_EN
    if (dir_q) begin
      if (nib <= 4'd9) begin
        dig_res = nib + 4'd3;
        dig_bad = 1'b0;
      end
    end else begin
      if (nib >= 4'd3 && nib <= 4'd12) begin
        dig_res = nib - 4'd3;
        dig_bad = 1'b0;
      end
    end
`else
    if (nib >= 4'd3 && nib <= 4'd12) begin
      dig_res = nib - 4'd3;
      dig_bad = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    mask_d  = mask_q;
    err_d   = err_q;
`ifdef XS3_BIDIR_EN
    dir_d   = dir_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StConv;
          sh_d    = din;
          cnt_d   = '0;
          mask_d  = '0;
          err_d   = 1'b0;
`ifdef XS3_BIDIR_EN
          dir_d   = dir;
`endif
        end
      end
      StConv: begin
        sh_d = sh_q >> 4;
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (cnt_q == CW'(i)) begin
            dout_d[4*i +: 4] = dig_res;
            mask_d[i]        = dig_bad;
          end
        end
        err_d = |mask_d;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // A simultaneous in_valid is not taken here; acceptance needs a full IDLE cycle.
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

`ifdef XS3_BIDIR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign dout      = dout_q;
  assign err       = err_q;
  assign err_mask  = mask_q;

endmodule

// File: tb/tb_xs3_bcd_seq_conv.sv
// Self-checking bench for xs3_bcd_seq_conv: directed vectors plus randomized words vs a digit model.
module tb_xs3_bcd_seq_conv;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      din;
  logic              dir;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      dout;
  logic              err;
  logic [DIGITS-1:0] err_mask;

  int checks = 0;
  int errors = 0;

  xs3_bcd_seq_conv #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
`ifdef XS3_BIDIR_EN
    .dir       (dir),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err),
    .err_mask  (err_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Digit-by-digit reference: decode (d=0) accepts 3..12 and subtracts 3,
  // encode (d=1) accepts 0..9 and adds 3; anything else becomes F and flags the digit.
  function automatic void model(input logic [W-1:0] w, input logic d,
                                output logic [W-1:0] r, output logic [DIGITS-1:0] m);
    int c;
    int v;
    bit ok;
    r = '0;
    m = '0;
    for (int i = 0; i < DIGITS; i++) begin
      c = int'((w >> (4 * i)) & W'(15));
      if (!d) begin
        ok = (c >= 3) && (c <= 12);
        v  = c - 3;
      end else begin
        ok = (c <= 9);
        v  = c + 3;
      end
      r[4*i +: 4] = ok ? 4'(v) : 4'hF;
      m[i]        = !ok;
    end
  endfunction

  task automatic accept(input logic [W-1:0] w, input logic d);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    din      = w;
    dir      = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    din      = W'($urandom);
`ifdef XS3_BIDIR_EN
    dir      = 1'($urandom);
`endif
  endtask

  task automatic expect_result(input logic [W-1:0] w, input logic d, input int stall);
    logic [W-1:0]      er;
    logic [DIGITS-1:0] em;
    int n = 0;
    model(w, d, er, em);
    while (!out_valid && n < 3 * DIGITS + 4) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout: word=%h out_valid=%b required 1", w, out_valid);
      return;
    end
    repeat (stall) begin
      @(posedge clk); #1;
    end
    checks++;
    if (dout !== er) begin
      errors++;
      $display("FAIL dout: word=%h dir=%b dout=%h required %h", w, d, dout, er);
    end
    checks++;
    if (err_mask !== em) begin
      errors++;
      $display("FAIL err_mask: word=%h dir=%b err_mask=%b required %b", w, d, err_mask, em);
    end
    checks++;
    if (err !== (|em)) begin
      errors++;
      $display("FAIL err: word=%h err=%b required %b", w, err, |em);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL handshake_return: out_valid,in_ready=%b required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, dout, err, err_mask} !== {1'b1, 1'b0, W'(0), 1'b0, DIGITS'(0)}) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b dout=%h err=%b err_mask=%b required 1 0 0 0 0",
               in_ready, out_valid, dout, err, err_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    accept(16'h3456, 1'b0);
    for (int k = 1; k <= int'(DIGITS); k++) begin
      @(posedge clk); #1;
      checks++;
      if (k < int'(DIGITS)) begin
        if ({out_valid, in_ready} !== 2'b00) begin
          errors++;
          $display("FAIL latency_conv: edge=%0d out_valid,in_ready=%b required 00", k,
                   {out_valid, in_ready});
        end
      end else if ({out_valid, in_ready} !== 2'b10) begin
        errors++;
        $display("FAIL latency_done: edge=%0d out_valid,in_ready=%b required 10", k,
                 {out_valid, in_ready});
      end
    end
    expect_result(16'h3456, 1'b0, 0);
  endtask

  task automatic test_vectors();
    logic [W-1:0] vec [4];
    vec[0] = 16'hCCCC;
    vec[1] = 16'h3333;
    vec[2] = 16'h3F43;
    vec[3] = 16'h0000;
    foreach (vec[i]) begin
      accept(vec[i], 1'b0);
      expect_result(vec[i], 1'b0, 0);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]      w1 = 16'h3F43;
    logic [W-1:0]      w2 = 16'h789A;
    logic [W-1:0]      er;
    logic [DIGITS-1:0] em;
    int n = 0;
    model(w1, 1'b0, er, em);
    accept(w1, 1'b0);
    while (!out_valid && n < 3 * DIGITS) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      din = W'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, dout, err, err_mask} !== {1'b1, 1'b0, er, |em, em}) begin
        errors++;
        $display("FAIL backpressure_hold: cycle=%0d ov=%b ir=%b dout=%h err=%b mask=%b required 1 0 %h %b %b",
                 k, out_valid, in_ready, dout, err, err_mask, er, |em, em);
      end
    end
    din       = w2;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: out_valid,in_ready=%b required 01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_accept: in_ready=%b required 0", in_ready);
    end
    expect_result(w2, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    accept(16'h4567, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, in_ready, dout, err_mask} !== {1'b0, 1'b1, W'(0), DIGITS'(0)}) begin
      errors++;
      $display("FAIL reset_mid: ov=%b ir=%b dout=%h mask=%b required 0 1 0 0",
               out_valid, in_ready, dout, err_mask);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (DIGITS + 2) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen || !in_ready) begin
      errors++;
      $display("FAIL reset_abort: out_valid_seen=%b in_ready=%b required 0 1", seen, in_ready);
    end
    accept(16'hC3A5, 1'b0);
    expect_result(16'hC3A5, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    logic         d;
    for (int i = 0; i < 24; i++) begin
      w = W'($urandom);
`ifdef XS3_BIDIR_EN
      d = 1'($urandom);
`else
      d = 1'b0;
`endif
      accept(w, d);
      expect_result(w, d, int'($urandom_range(0, 3)));
    end
  endtask

`ifdef XS3_BIDIR_EN
  task automatic test_bidir();
    accept(16'h0129, 1'b1);
    expect_result(16'h0129, 1'b1, 0);
    accept(16'h0A29, 1'b1);
    expect_result(16'h0A29, 1'b1, 0);
    accept(16'h3456, 1'b0);
    expect_result(16'h3456, 1'b0, 0);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    dir       = 1'b0;
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_reset_mid();
`ifdef XS3_BIDIR_EN
    test_bidir();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
